// File: rtl/crc_engine.sv
// Parametrised framed CRC generator: DATA_W bits per accepted beat, MSB first.
// Latency: result strobe (out_valid) 1 clock after the accepted in_last beat.
// Backpressure: in_ready high only while a frame is open (RUN); optional compare via CRC_CHECK_EN.
module crc_engine #(
   parameter int               CRC_W   = 5,
   parameter logic [CRC_W-1:0] POLY    = 5'h09,
   parameter logic [CRC_W-1:0] INIT    = '0,
   parameter logic [CRC_W-1:0] XOR_OUT = '0,
   parameter int               DATA_W  = 1,
   parameter int               CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic [CRC_W-1:0]  crc_out,
   output logic              out_valid,
   output logic              busy,
   output logic [CNT_W-1:0]  beat_cnt
`ifdef CRC_CHECK_EN
   ,
   input  logic [CRC_W-1:0]  chk_val,
   output logic              chk_ok
`endif
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state_q;
   state_t           state_d;
   logic [CRC_W-1:0] crc_q;
   logic [CRC_W-1:0] crc_nxt;
   logic             accept;
   logic             finish;

   // Unrolled serial LFSR: all DATA_W bit steps happen in one cycle, MSB first.
   function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                 input logic [DATA_W-1:0] d);
      logic [CRC_W-1:0] r;
      logic             fb;
      r = c;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         fb = d[i] ^ r[CRC_W-1];
         r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      end
      return r;
   endfunction

   assign crc_nxt = crc_step(crc_q, in_data);

   // Handshake decode and next-state logic; start always takes priority over a beat.
   always_comb begin
      state_d  = state_q;
      in_ready = (state_q == RUN);
      busy     = (state_q == RUN);
      accept   = 1'b0;
      finish   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            accept = in_valid && !start;
            finish = accept && in_last;
            if (finish) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // CRC register, beat counter and the registered one-cycle result strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         crc_q     <= '0;
         crc_out   <= '0;
         out_valid <= 1'b0;
         beat_cnt  <= '0;
      end else begin
         out_valid <= 1'b0;
         if (start) begin
            crc_q    <= INIT;
            beat_cnt <= '0;
         end else if (accept) begin
            crc_q <= crc_nxt;
            if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
            if (in_last) begin
               crc_out   <= crc_nxt ^ XOR_OUT;
               out_valid <= 1'b1;
            end
         end
      end
   end

`ifdef CRC_CHECK_EN
   // Compare the final CRC against the expected value captured with the last beat.
   always_ff @(posedge clk) begin
      if (reset)       chk_ok <= 1'b0;
      else if (finish) chk_ok <= ((crc_nxt ^ XOR_OUT) == chk_val);
      else             chk_ok <= 1'b0;
   end
`endif

endmodule
